// File: rtl/axi_burst_master_if.sv
// AXI4 master-side channel bundle for axi_burst_master.
// The master modport drives AW/W/AR channels plus BREADY/RREADY;
// the slave modport is its mirror image for a memory model or interconnect.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master. A command (read or write, INCR
// burst, full-width beats) is accepted in IDLE, issued on AW/AR, its data
// streamed through combinationally, and completion reported by a one-cycle
// done pulse carrying the response code and a protocol-error flag.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | cmd_ready high, waiting for a command
// S_WR_ADDR | awvalid high, waiting for awready
// S_WR_DATA | wr_* stream passed to W channel, counting beats
// S_WR_RESP | bready high, waiting for the write response
// S_RD_ADDR | arvalid high, waiting for arready
// S_RD_DATA | R channel passed to rd_* stream, counting beats
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,

    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,

    axi_burst_master_if.master    m_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            resp_acc_q, resp_acc_d;
    logic                  err_acc_q, err_acc_d;
    logic                  done_q, done_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic                  done_err_q, done_err_d;

    logic in_wr_data;
    logic in_rd_data;
    logic beat_last;
    logic wr_beat;
    logic rd_beat;

    assign in_wr_data = (state_q == S_WR_DATA);
    assign in_rd_data = (state_q == S_RD_DATA);
    assign beat_last  = (cnt_q == len_q);
    assign wr_beat    = in_wr_data && wr_valid && m_axi.wready;
    assign rd_beat    = in_rd_data && m_axi.rvalid && rd_ready;

    // Next-state and next-register values for the whole controller.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        resp_acc_d  = resp_acc_q;
        err_acc_d   = err_acc_q;
        done_d      = 1'b0;
        done_resp_d = 2'b00;
        done_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    id_d       = cmd_id;
                    addr_d     = cmd_addr & ~ALIGN_MASK;
                    len_d      = cmd_len;
                    resp_acc_d = 2'b00;
                    err_acc_d  = 1'b0;
                    state_d    = cmd_write ? S_WR_ADDR : S_RD_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (awvalid_q && m_axi.awready) begin
                    cnt_d   = 8'd0;
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (wr_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (beat_last) begin
                        state_d = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    done_d      = 1'b1;
                    done_resp_d = m_axi.bresp;
                    done_err_d  = (m_axi.bid != id_q);
                    state_d     = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (arvalid_q && m_axi.arready) begin
                    cnt_d   = 8'd0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rd_beat) begin
                    cnt_d      = cnt_q + 8'd1;
                    resp_acc_d = (m_axi.rresp > resp_acc_q) ? m_axi.rresp : resp_acc_q;
                    err_acc_d  = err_acc_q || (m_axi.rlast != beat_last) || (m_axi.rid != id_q);
                    // A slave that ends the burst early still terminates it here.
                    if (beat_last || m_axi.rlast) begin
                        done_d      = 1'b1;
                        done_resp_d = resp_acc_d;
                        done_err_d  = err_acc_d;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        awvalid_d   = (state_d == S_WR_ADDR);
        arvalid_d   = (state_d == S_RD_ADDR);
    end

    // Controller registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            resp_acc_q  <= 2'b00;
            err_acc_q   <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            done_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            resp_acc_q  <= resp_acc_d;
            err_acc_q   <= err_acc_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            done_err_q  <= done_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign done_err  = done_err_q;

    assign m_axi.awid    = id_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = wr_data;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = in_wr_data && beat_last;
    assign m_axi.wvalid  = in_wr_data && wr_valid;
    assign wr_ready      = in_wr_data && m_axi.wready;

    assign m_axi.bready  = (state_q == S_WR_RESP);

    assign m_axi.arid    = id_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = AXI_SIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;

    assign m_axi.rready  = in_rd_data && rd_ready;
    assign rd_valid      = in_rd_data && m_axi.rvalid;
    assign rd_data       = m_axi.rdata;
    assign rd_last       = in_rd_data && m_axi.rlast;
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a randomising AXI slave with a small memory,
// a write-data source and read-data sink with random gaps, and a directed
// sequence whose expectations come from a word-array reference model.
module tb_axi_burst_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_id = 8'd0;
    logic [7:0]  cmd_addr = 8'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic        done_err;

    axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ID_WIDTH(8)) m_axi ();

    axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ID_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .m_axi(m_axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // knobs set by the directed sequence
    int         aw_pct = 100, w_pct = 100, ar_pct = 100, r_pct = 100;
    int         wv_pct = 100, rd_pct = 100;
    logic [1:0] bresp_k = 2'd0;
    logic [7:0] bid_xor = 8'd0, rid_xor = 8'd0;
    int         stop_k = -1;
    logic [1:0] r_resp_arr [256];
    logic [31:0] wr_arr [256];
    int         wr_base = 0, wr_n = 0;
    bit         wr_en = 1'b0;
    logic [31:0] ref_mem [64];

    // slave state and logs
    logic [31:0] smem [64];
    int          w_base, w_beat, r_base, r_beat, r_stop;
    bit          r_active;
    logic [7:0]  r_id;
    int          aw_cnt = 0, ar_cnt = 0;
    logic [7:0]  aw_id_l, aw_addr_l, aw_len_l, ar_id_l, ar_addr_l, ar_len_l;
    logic [2:0]  aw_size_l, aw_prot_l, ar_size_l;
    logic [1:0]  aw_burst_l, ar_burst_l;
    logic [3:0]  aw_cache_l;
    logic        aw_lock_l;
    logic [31:0] wlog_d [1024];
    logic        wlog_l [1024];
    int          wlog_n = 0, strb_bad = 0, wr_hs_cnt = 0;
    logic [31:0] rlog_d [1024];
    logic        rlog_l [1024];
    int          rlog_n = 0;
    int          done_cnt = 0;
    logic [1:0]  done_resp_cap = 2'd0;
    logic        done_err_cap = 1'b0;
    int          stab_bad = 0;
    bit          aw_hold, w_hold, ar_hold;
    logic [23:0] aw_prev, ar_prev;
    logic [32:0] w_prev;

    // AXI slave: random readies, memory, B response, R beats with gaps.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi.awready <= 1'b0; m_axi.wready <= 1'b0; m_axi.arready <= 1'b0;
            m_axi.bvalid <= 1'b0; m_axi.bid <= 8'd0; m_axi.bresp <= 2'd0;
            m_axi.rvalid <= 1'b0; m_axi.rid <= 8'd0; m_axi.rdata <= 32'd0;
            m_axi.rresp <= 2'd0; m_axi.rlast <= 1'b0;
            r_active <= 1'b0; r_beat <= 0;
        end else begin
            m_axi.awready <= ($urandom_range(0, 99) < aw_pct);
            m_axi.wready  <= ($urandom_range(0, 99) < w_pct);
            m_axi.arready <= ($urandom_range(0, 99) < ar_pct);
            if (m_axi.awvalid && m_axi.awready) begin
                aw_cnt <= aw_cnt + 1;
                aw_id_l <= m_axi.awid; aw_addr_l <= m_axi.awaddr; aw_len_l <= m_axi.awlen;
                aw_size_l <= m_axi.awsize; aw_burst_l <= m_axi.awburst; aw_lock_l <= m_axi.awlock;
                aw_cache_l <= m_axi.awcache; aw_prot_l <= m_axi.awprot;
                w_base <= int'(m_axi.awaddr) >> 2; w_beat <= 0;
            end
            if (m_axi.wvalid && m_axi.wready) begin
                smem[(w_base + w_beat) & 63] <= m_axi.wdata;
                w_beat <= w_beat + 1;
                if (m_axi.wlast) begin
                    m_axi.bvalid <= 1'b1;
                    m_axi.bid    <= aw_id_l ^ bid_xor;
                    m_axi.bresp  <= bresp_k;
                end
            end
            if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;
            if (!m_axi.rvalid || m_axi.rready) begin
                if (m_axi.rvalid) begin
                    r_beat <= r_beat + 1;
                    if (m_axi.rlast) r_active <= 1'b0;
                end
                if (r_active && !(m_axi.rvalid && m_axi.rlast) && ($urandom_range(0, 99) < r_pct)) begin
                    m_axi.rvalid <= 1'b1;
                    m_axi.rdata  <= smem[(r_base + r_beat + (m_axi.rvalid ? 1 : 0)) & 63];
                    m_axi.rlast  <= ((r_beat + (m_axi.rvalid ? 1 : 0)) == r_stop);
                    m_axi.rresp  <= r_resp_arr[(r_beat + (m_axi.rvalid ? 1 : 0)) & 255];
                    m_axi.rid    <= r_id;
                end else begin
                    m_axi.rvalid <= 1'b0;
                end
            end
            if (m_axi.arvalid && m_axi.arready) begin
                ar_cnt <= ar_cnt + 1;
                ar_id_l <= m_axi.arid; ar_addr_l <= m_axi.araddr; ar_len_l <= m_axi.arlen;
                ar_size_l <= m_axi.arsize; ar_burst_l <= m_axi.arburst;
                r_active <= 1'b1; r_beat <= 0; r_base <= int'(m_axi.araddr) >> 2;
                r_stop <= (stop_k < 0) ? int'(m_axi.arlen) : stop_k;
                r_id <= m_axi.arid ^ rid_xor;
                m_axi.rvalid <= 1'b0;
            end
        end
    end

    // Beat, done and handshake logs.
    always @(posedge clk) begin
        if (m_axi.wvalid && m_axi.wready) begin
            wlog_d[wlog_n & 1023] <= m_axi.wdata;
            wlog_l[wlog_n & 1023] <= m_axi.wlast;
            wlog_n <= wlog_n + 1;
            if (m_axi.wstrb !== 4'hF) strb_bad <= strb_bad + 1;
        end
        if (wr_valid && wr_ready) wr_hs_cnt <= wr_hs_cnt + 1;
        if (rd_valid && rd_ready) begin
            rlog_d[rlog_n & 1023] <= rd_data;
            rlog_l[rlog_n & 1023] <= rd_last;
            rlog_n <= rlog_n + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_resp_cap <= done_resp;
            done_err_cap <= done_err;
        end
    end

    // Payload must not change while a valid is waiting for its ready.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
        end else begin
            if (aw_hold && (m_axi.awvalid !== 1'b1 ||
                {m_axi.awid, m_axi.awaddr, m_axi.awlen} !== aw_prev)) stab_bad <= stab_bad + 1;
            if (w_hold && (m_axi.wvalid !== 1'b1 ||
                {m_axi.wdata, m_axi.wlast} !== w_prev)) stab_bad <= stab_bad + 1;
            if (ar_hold && (m_axi.arvalid !== 1'b1 ||
                {m_axi.arid, m_axi.araddr, m_axi.arlen} !== ar_prev)) stab_bad <= stab_bad + 1;
            aw_hold <= m_axi.awvalid && !m_axi.awready;
            w_hold  <= m_axi.wvalid && !m_axi.wready;
            ar_hold <= m_axi.arvalid && !m_axi.arready;
            aw_prev <= {m_axi.awid, m_axi.awaddr, m_axi.awlen};
            w_prev  <= {m_axi.wdata, m_axi.wlast};
            ar_prev <= {m_axi.arid, m_axi.araddr, m_axi.arlen};
        end
    end

    // Write-data source: holds valid and data until accepted.
    initial begin
        int seen;
        int idx;
        seen = 0;
        wr_valid = 1'b0;
        wr_data = 32'd0;
        forever begin
            @(negedge clk);
            idx = wr_hs_cnt - wr_base;
            if (!wr_en || idx >= wr_n) begin
                wr_valid = 1'b0;
            end else begin
                if (!wr_valid || wr_hs_cnt != seen) wr_valid = ($urandom_range(0, 99) < wv_pct);
                wr_data = wr_arr[idx & 255];
            end
            seen = wr_hs_cnt;
        end
    end

    // Read-data sink: ready toggles freely.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            rd_ready = ($urandom_range(0, 99) < rd_pct);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input bit w, input logic [7:0] id, input logic [7:0] addr, input logic [7:0] len);
        int k;
        cmd_valid = 1'b1; cmd_write = w; cmd_id = id; cmd_addr = addr; cmd_len = len;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("cmd_accept_wait", 64'(k < 50), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (w) check("awvalid_after_accept", 64'(m_axi.awvalid), 64'd1);
        else   check("arvalid_after_accept", 64'(m_axi.arvalid), 64'd1);
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 3000) begin @(negedge clk); k++; end
        check("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (3) @(negedge clk);
        check("done_single_pulse", 64'(done_cnt), 64'(d0 + 1));
    endtask

    task automatic do_write(input logic [7:0] id, input logic [7:0] addr, input int len,
                            input logic [1:0] bresp, input logic [7:0] bx);
        int d0, a0, w0;
        d0 = done_cnt; a0 = aw_cnt; w0 = wlog_n;
        bresp_k = bresp; bid_xor = bx;
        wr_base = wr_hs_cnt; wr_n = len + 1; wr_en = 1'b1;
        send_cmd(1'b1, id, addr, 8'(len));
        wait_done(d0);
        wr_en = 1'b0;
        check("aw_count", 64'(aw_cnt - a0), 64'd1);
        check("aw_addr", 64'(aw_addr_l), 64'(addr & 8'hFC));
        check("aw_len", 64'(aw_len_l), 64'(len));
        check("aw_id", 64'(aw_id_l), 64'(id));
        check("aw_size", 64'(aw_size_l), 64'd2);
        check("aw_burst", 64'(aw_burst_l), 64'd1);
        check("aw_lock_cache_prot", 64'({aw_lock_l, aw_cache_l, aw_prot_l}), 64'({1'b0, 4'b0011, 3'b000}));
        check("w_beats", 64'(wlog_n - w0), 64'(len + 1));
        for (int i = 0; i <= len; i++) begin
            check("w_data", 64'(wlog_d[(w0 + i) & 1023]), 64'(wr_arr[i]));
            check("w_last", 64'(wlog_l[(w0 + i) & 1023]), 64'(i == len));
            ref_mem[((int'(addr) >> 2) + i) & 63] = wr_arr[i];
        end
        check("wr_done_resp", 64'(done_resp_cap), 64'(bresp));
        check("wr_done_err", 64'(done_err_cap), 64'(bx != 8'd0));
        check("wstrb_all_ones", 64'(strb_bad), 64'd0);
        check("payload_stable", 64'(stab_bad), 64'd0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [7:0] addr, input int len,
                           input int stop, input logic [7:0] rx);
        int d0, a0, r0, stop_eff, nb, rr;
        bit err, lastb;
        logic [1:0] mx;
        stop_eff = (stop < 0) ? len : stop;
        nb = 0; err = (rx != 8'd0); mx = 2'd0;
        for (int i = 0; i <= len; i++) begin
            nb++;
            lastb = (i == stop_eff);
            if (lastb != (i == len)) err = 1'b1;
            if (r_resp_arr[i] > mx) mx = r_resp_arr[i];
            if (lastb || i == len) break;
        end
        d0 = done_cnt; a0 = ar_cnt; r0 = rlog_n;
        stop_k = stop; rid_xor = rx;
        send_cmd(1'b0, id, addr, 8'(len));
        wait_done(d0);
        rr = 0;
        repeat (4) begin @(negedge clk); if (m_axi.rready !== 1'b0) rr++; end
        check("rready_after_done", 64'(rr), 64'd0);
        check("ar_count", 64'(ar_cnt - a0), 64'd1);
        check("ar_addr", 64'(ar_addr_l), 64'(addr & 8'hFC));
        check("ar_len_id", 64'({ar_len_l, ar_id_l}), 64'({8'(len), id}));
        check("ar_size_burst", 64'({ar_size_l, ar_burst_l}), 64'({3'd2, 2'd1}));
        check("r_beats", 64'(rlog_n - r0), 64'(nb));
        for (int i = 0; i < nb; i++) begin
            check("rd_data", 64'(rlog_d[(r0 + i) & 1023]), 64'(ref_mem[((int'(addr) >> 2) + i) & 63]));
            check("rd_last", 64'(rlog_l[(r0 + i) & 1023]), 64'(i == stop_eff));
        end
        check("rd_done_resp", 64'(done_resp_cap), 64'(mx));
        check("rd_done_err", 64'(done_err_cap), 64'(err));
        stop_k = -1; rid_xor = 8'd0;
    endtask

    initial begin
        int k, d0, w0, w1, len;
        logic [7:0] addr;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 256; i++) r_resp_arr[i] = 2'd0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_valids", 64'({m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready, m_axi.rready}), 64'd0);
        check("rst_done", 64'({done, done_resp, done_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("cmd_ready_first_edge", 64'(cmd_ready), 64'd1);

        // basic write / read of 4 beats
        for (int i = 0; i < 4; i++) wr_arr[i] = 32'hA0 + 32'(i);
        do_write(8'h05, 8'h10, 3, 2'd0, 8'd0);
        do_read(8'h05, 8'h10, 3, -1, 8'd0);

        // unaligned single-beat write
        wr_arr[0] = 32'hDEADBEEF;
        do_write(8'h07, 8'h13, 0, 2'd0, 8'd0);
        do_read(8'h07, 8'h10, 0, -1, 8'd0);

        // slave ends read early on beat 2
        do_read(8'h05, 8'h10, 3, 1, 8'd0);

        // long bursts with random gaps and random read responses
        aw_pct = 40; w_pct = 50; ar_pct = 40; r_pct = 50; wv_pct = 50; rd_pct = 50;
        for (int i = 0; i < 16; i++) wr_arr[i] = $urandom;
        do_write(8'h21, 8'h40, 15, 2'd0, 8'd0);
        for (int i = 0; i < 16; i++) r_resp_arr[i] = 2'($urandom_range(0, 3));
        do_read(8'h22, 8'h40, 15, -1, 8'd0);
        for (int i = 0; i < 256; i++) r_resp_arr[i] = 2'd0;

        // response / ID errors
        for (int i = 0; i < 2; i++) wr_arr[i] = $urandom;
        do_write(8'h33, 8'h20, 1, 2'd2, 8'h01);
        do_read(8'h33, 8'h10, 2, 1000, 8'd0);
        do_read(8'h34, 8'h40, 1, -1, 8'h80);

        // reset during the second write beat
        aw_pct = 100; w_pct = 100; ar_pct = 100; r_pct = 100; wv_pct = 100; rd_pct = 100;
        for (int i = 0; i < 4; i++) wr_arr[i] = 32'h5500 + 32'(i);
        d0 = done_cnt; w0 = wlog_n;
        wr_base = wr_hs_cnt; wr_n = 4; wr_en = 1'b1;
        send_cmd(1'b1, 8'h44, 8'h80, 8'd3);
        k = 0;
        while (wlog_n == w0 && k < 100) begin @(negedge clk); k++; end
        check("first_beat_before_rst", 64'(wlog_n - w0), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valids", 64'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, wr_ready}), 64'd0);
        check("rst_mid_done", 64'({done, cmd_ready}), 64'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        w1 = wlog_n;
        repeat (10) @(negedge clk);
        check("no_beats_after_rst", 64'(wlog_n - w1), 64'd0);
        check("no_done_after_rst", 64'(done_cnt), 64'(d0));
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 4; i++) wr_arr[i] = 32'h6600 + 32'(i);
        do_write(8'h45, 8'h80, 3, 2'd0, 8'd0);
        do_read(8'h45, 8'h80, 3, -1, 8'd0);

        // random transactions
        aw_pct = 60; w_pct = 60; ar_pct = 60; r_pct = 60; wv_pct = 70; rd_pct = 70;
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(0, 7);
            addr = 8'($urandom_range(0, 63 - len) * 4 + $urandom_range(0, 3));
            for (int i = 0; i <= len; i++) wr_arr[i] = $urandom;
            do_write(8'($urandom), addr, len, 2'($urandom_range(0, 3)), 8'd0);
            for (int i = 0; i <= len; i++) r_resp_arr[i] = 2'($urandom_range(0, 3));
            do_read(8'($urandom), addr, len, -1, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, AXI byte-address width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, AXI ID width; STRB_WIDTH SHALL be a localparam equal to DATA_WIDTH/8.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, all logic on rising edge.
  rst  in  1  reset, asynchronous, active-high.
  cmd_valid/cmd_ready  in/out  1/1  command handshake.
  cmd_write  in  1  1=write burst, 0=read burst.
  cmd_id  in  ID_WIDTH  transaction ID.
  cmd_addr  in  ADDR_WIDTH  start byte address.
  cmd_len  in  8  beats minus one (AXI len).
  wr_data/wr_valid/wr_ready  in/in/out  DATA_WIDTH/1/1  write-data stream in.
  rd_data/rd_last/rd_valid/rd_ready  out/out/out/in  DATA_WIDTH/1/1/1  read-data stream out.
  done  out  1  one-cycle completion pulse.
  done_resp  out  2  completion response code.
  done_err  out  1  protocol error (RLAST mismatch or ID mismatch).
  m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4 master channels, full signal set (id, addr, len, size, burst, lock, cache, prot, valid, ready; wdata, wstrb, wlast; bid, bresp; rid, rdata, rresp, rlast).

Function
REQ-005 SHALL be a single-outstanding master: one command in flight; states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-006 cmd_ready SHALL be registered, high only in IDLE; cmd_valid&&cmd_ready latches id/addr/len/write and moves to WR_ADDR or RD_ADDR next cycle.
REQ-007 Latched address SHALL have its low log2(STRB_WIDTH) bits forced to 0.
REQ-008 awvalid/arvalid SHALL be registered, assert the cycle after acceptance, and hold with stable payload until the matching ready.
REQ-009 Constant fields: size=log2(STRB_WIDTH), burst=2'b01 (INCR), lock=0, cache=4'b0011, prot=3'b000, wstrb all ones.
REQ-010 AW handshake SHALL move to WR_DATA; in WR_DATA wvalid=wr_valid, wr_ready=wready, wdata=wr_data (combinational pass-through); both forced 0 outside WR_DATA.
REQ-011 An 8-bit beat counter SHALL clear on entry to WR_DATA/RD_DATA and increment per data handshake; wlast SHALL equal (count==len).
REQ-012 Handshake with wlast=1 SHALL move to WR_RESP; bready SHALL be 1 only in WR_RESP.
REQ-013 B handshake SHALL pulse done for one cycle with done_resp=bresp, done_err=(bid!=latched id), then IDLE.
REQ-014 AR handshake SHALL move to RD_DATA; in RD_DATA rready=rd_ready, rd_valid=rvalid, rd_data=rdata, rd_last=rlast (pass-through); rready forced 0 outside RD_DATA.
REQ-015 Read response SHALL accumulate the maximum rresp across beats; error flag SHALL set if rlast!=(count==len) on any beat or rid!=latched id.
REQ-016 Read completes on the beat where count==len OR rlast=1, whichever first; done pulses next cycle with done_resp=accumulated max, done_err=error flag; then IDLE.
REQ-017 Beats after early completion SHALL NOT be accepted (rready=0 in IDLE).
REQ-018 Stall on any ready/valid low SHALL freeze state, counter and payload indefinitely; no timeout.
REQ-019 cmd_len=0 SHALL give a single beat with wlast=1 (write) / completion on first beat (read).

Reset
REQ-020 rst high SHALL immediately force state IDLE, cmd_ready=0, awvalid=arvalid=bready=0, done=0, done_err=0, done_resp=0, counter=0, error/resp accumulators=0; pass-through outputs follow state (zero valids/readies).
REQ-021 cmd_ready SHALL rise on the first rising edge after rst deasserts.
REQ-022 rst mid-burst SHALL abandon the transaction without done; no further AXI beats issued.

Verification
REQ-023 Write id=0x05 addr=0x10 len=3, data 0xA0..0xA3, slave bresp=0 -> AW len=3 size=2 burst=1, 4 W beats, wlast on 4th only, done=1 resp=0 err=0.
REQ-024 Read id=0x05 addr=0x10 len=3 after REQ-023 -> rd_data 0xA0..0xA3, rd_last on 4th, done resp=0 err=0.
REQ-025 cmd_addr=0x13 len=0 write -> awaddr=0x10, single beat wlast=1.
REQ-026 Slave asserts rlast on beat 2 of len=3 read -> completion after beat 2, done_err=1, no rready afterward.
REQ-027 Random wr_valid/rd_ready/awready/wready gaps on len=15 burst -> data in order, payloads stable while valid high.
REQ-028 rst pulse during WR_DATA beat 2 -> awvalid/wvalid/bready 0 immediately, no done, next command completes normally.
